// File: rtl/sampq_pkg.sv
// Shared constants and helpers for the sample queue reader and writer.
package sampq_pkg;

  // Widest pointer the shared increment helper handles.
  localparam int unsigned PtrMaxW = 32;

  // Default geometry of the sample queue.
  localparam int unsigned QueueSizeDef = 128;
  localparam int unsigned SampleWDef   = 72;
  localparam int unsigned AddrWDef     = 13;

  // Bytes per sample.
  function automatic int unsigned nbytes_of(input int unsigned sample_w);
    return sample_w / 8;
  endfunction

  // Byte-counter width; at least one bit so a one-byte sample still has a counter.
  function automatic int unsigned cnt_w_of(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  localparam int unsigned NBYTES = nbytes_of(SampleWDef);
  localparam int unsigned CntWDef = cnt_w_of(NBYTES);

  // Pointer increment with wrap: returns {wrap, ptr}. The wrap bit toggles when
  // the pointer rolls from size-1 back to 0. Shared with the writer side.
  function automatic logic [PtrMaxW:0] ptr_inc(input logic               wrap,
                                               input logic [PtrMaxW-1:0] ptr,
                                               input int unsigned        size);
    logic [PtrMaxW:0] res;
    if (ptr == PtrMaxW'(size - 1)) begin
      res = {~wrap, {PtrMaxW{1'b0}}};
    end else begin
      res = {wrap, ptr + 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/sampq_serializer.sv
// Serialises one sample into bytes, least-significant byte first, over valid/ready.
module sampq_serializer
  import sampq_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 72
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                load_valid_i,
  input  logic [SAMPLE_W-1:0] load_data_i,
  output logic                load_ready_o,
  output logic                last_o,
  output logic [7:0]          out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int unsigned NBytes = nbytes_of(SAMPLE_W);
  localparam int unsigned CntW   = cnt_w_of(NBytes);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                accept, last_accept, load;

  assign accept      = valid_q & out_ready_i;
  assign last_accept = accept & (cnt_q == LastCnt);
  // A new sample may enter when idle or as the final byte leaves, so there is no bubble.
  assign load_ready_o = ~valid_q | last_accept;
  assign load         = load_valid_i & load_ready_o;
  assign last_o       = last_accept;

  assign out_data_o  = shift_q[7:0];
  assign out_valid_o = valid_q;

  // Next-state: flush beats load, load beats shifting out.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (flush_i) begin
      shift_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      shift_d = load_data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q >> 8;
      cnt_d   = cnt_q + 1'b1;
      if (last_accept) begin
        valid_d = 1'b0;
      end
    end
  end

  // Shift register, byte counter and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/sampq_reader.sv
// Read side of the sample queue: fetches samples from RAM and streams them as bytes.
module sampq_reader
  import sampq_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = 128,
  parameter int unsigned SAMPLE_W   = 72,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   wptr,
  input  logic                wwrap,
  output logic [ADDR_W-1:0]   rptr,
  output logic                rwrap,
  output logic [ADDR_W-1:0]   raddr,
  output logic                ravail,
  input  logic [SAMPLE_W-1:0] rdata,
  input  logic                flush,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [ADDR_W-1:0]   fptr_q, fptr_d;
  logic                fwrap_q, fwrap_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic                rwrap_q, rwrap_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                ravail_q, ravail_d;
  logic [SAMPLE_W-1:0] nbuf_q, nbuf_d;
  logic                nbuf_valid_q, nbuf_valid_d;

  logic                empty, cap, issue, nbuf_drain;
  logic                ser_load_valid, ser_load_ready, ser_last;
  logic [SAMPLE_W-1:0] ser_load_data;
  logic [PtrMaxW:0]    f_inc, r_inc;
  logic                unused_inc_bits;

  assign empty = ({fwrap_q, fptr_q} == {wwrap, wptr});
  // A read issued last cycle returns now; flush cancels it.
  assign cap   = ravail_q & ~flush;

  // nbuf is older than anything returning from RAM, so it loads first.
  assign ser_load_valid = nbuf_valid_q | cap;
  assign ser_load_data  = nbuf_valid_q ? nbuf_q : rdata;
  assign nbuf_drain     = nbuf_valid_q & ser_load_ready;

  // One read in flight at most, and only when its data is guaranteed a home.
  assign issue = ~flush & ~empty & ~ravail_q & (~nbuf_valid_q | nbuf_drain);

  assign f_inc = ptr_inc(fwrap_q, PtrMaxW'(fptr_q), QUEUE_SIZE);
  assign r_inc = ptr_inc(rwrap_q, PtrMaxW'(rptr_q), QUEUE_SIZE);
  assign unused_inc_bits = ^{f_inc[PtrMaxW-1:ADDR_W], r_inc[PtrMaxW-1:ADDR_W]};

  assign rptr   = rptr_q;
  assign rwrap  = rwrap_q;
  assign raddr  = raddr_q;
  assign ravail = ravail_q;

  // Pointer, read-issue and next-buffer control.
  always_comb begin
    fptr_d       = fptr_q;
    fwrap_d      = fwrap_q;
    rptr_d       = rptr_q;
    rwrap_d      = rwrap_q;
    raddr_d      = raddr_q;
    ravail_d     = 1'b0;
    nbuf_d       = nbuf_q;
    nbuf_valid_d = nbuf_valid_q;
    if (flush) begin
      fptr_d       = wptr;
      fwrap_d      = wwrap;
      rptr_d       = wptr;
      rwrap_d      = wwrap;
      nbuf_valid_d = 1'b0;
    end else begin
      if (issue) begin
        ravail_d = 1'b1;
        raddr_d  = fptr_q;
        fptr_d   = f_inc[ADDR_W-1:0];
        fwrap_d  = f_inc[PtrMaxW];
      end
      // Read pointer moves on capture so the writer never overwrites a pending slot.
      if (cap) begin
        rptr_d  = r_inc[ADDR_W-1:0];
        rwrap_d = r_inc[PtrMaxW];
      end
      if (nbuf_drain) begin
        nbuf_valid_d = 1'b0;
      end
      if (cap && (nbuf_valid_q || !ser_load_ready)) begin
        nbuf_d       = rdata;
        nbuf_valid_d = 1'b1;
      end
    end
  end

  // Pointer, read-port and next-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fptr_q       <= '0;
      fwrap_q      <= 1'b0;
      rptr_q       <= '0;
      rwrap_q      <= 1'b0;
      raddr_q      <= '0;
      ravail_q     <= 1'b0;
      nbuf_q       <= '0;
      nbuf_valid_q <= 1'b0;
    end else begin
      fptr_q       <= fptr_d;
      fwrap_q      <= fwrap_d;
      rptr_q       <= rptr_d;
      rwrap_q      <= rwrap_d;
      raddr_q      <= raddr_d;
      ravail_q     <= ravail_d;
      nbuf_q       <= nbuf_d;
      nbuf_valid_q <= nbuf_valid_d;
    end
  end

  sampq_serializer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .load_valid_i (ser_load_valid),
    .load_data_i  (ser_load_data),
    .load_ready_o (ser_load_ready),
    .last_o       (ser_last),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  // Last-byte strobe is not needed at this level.
  logic unused_ser_last;
  assign unused_ser_last = ser_last;

endmodule

// File: tb/tb_sampq_reader.sv
// Directed bench for sampq_reader with a small behavioural sample RAM.
module tb_sampq_reader;

  logic        clk;
  logic        rst_n;
  logic [12:0] wptr, rptr, raddr;
  logic        wwrap, rwrap, ravail, flush;
  logic [71:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  logic [71:0] mem [0:127];
  logic [7:0]  exp_q [$];
  logic [12:0] addr_q [$];
  int          total = 0;
  int          bad = 0;
  int          span = 0;

  assign rdata = mem[raddr[6:0]];

  sampq_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wptr      (wptr),
    .wwrap     (wwrap),
    .rptr      (rptr),
    .rwrap     (rwrap),
    .raddr     (raddr),
    .ravail    (ravail),
    .rdata     (rdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write a sample into the RAM model and queue its bytes, LSB first.
  task automatic push_sample(input int slot, input logic [71:0] data);
    mem[slot] = data;
    for (int j = 0; j < 9; j++) exp_q.push_back(data[8*j +: 8]);
  endtask

  // Consume nbytes from the stream; bp selects the 1,0,0,1 ready pattern.
  task automatic drain(input int nbytes, input bit bp, input int budget);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    bit stall = 1'b0;
    bit prev_ravail = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] want;
    while (got < nbytes && cyc < budget) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, stall_data);
      end
      if (ravail) begin
        addr_q.push_back(raddr);
        chk("one_in_flight", prev_ravail, 0);
      end
      prev_ravail = ravail;
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("byte", out_data, want);
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      stall = out_valid && !out_ready;
      stall_data = out_data;
      tick();
      cyc++;
    end
    chk("drain_count", got, nbytes);
    span = last - first + 1;
  endtask

  initial begin
    logic [71:0] s2 [5];
    bit seen_v, seen_r, found;
    s2[0] = 72'h191817161514131211;
    s2[1] = 72'h292827262524232221;
    s2[2] = 72'h393837363534333231;
    s2[3] = 72'h494847464544434241;
    s2[4] = 72'h595857565554535251;

    rst_n = 1'b0; wptr = '0; wwrap = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_rptr", rptr, 0);
    chk("rst_rwrap", rwrap, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_ravail", ravail, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    chk("empty_no_read", ravail, 0);

    // 1: single sample
    push_sample(0, 72'h090807060504030201);
    out_ready = 1'b1;
    wptr = 13'd1;
    tick();
    chk("t1_ravail", ravail, 1);
    chk("t1_raddr", raddr, 0);
    chk("t1_rptr_pending", rptr, 0);
    tick();
    chk("t1_rptr", rptr, 1);
    chk("t1_rwrap", rwrap, 0);
    drain(9, 1'b0, 30);
    chk("t1_idle", out_valid, 0);

    // 2: five back-to-back samples
    addr_q.delete();
    for (int i = 0; i < 5; i++) push_sample(i + 1, s2[i]);
    wptr = 13'd6;
    drain(45, 1'b0, 80);
    chk("t2_no_gaps", span, 45);
    chk("t2_reads", addr_q.size(), 5);
    for (int i = 0; i < 5 && i < addr_q.size(); i++) chk("t2_addr", addr_q[i], i + 1);
    chk("t2_rptr", rptr, 6);

    // 3: wrap from slot 127
    wptr = 13'd127;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_rptr_start", rptr, 127);
    chk("t3_rwrap_start", rwrap, 0);
    push_sample(127, 72'hA9A8A7A6A5A4A3A2A1);
    push_sample(0, 72'hB9B8B7B6B5B4B3B2B1);
    push_sample(1, 72'hC9C8C7C6C5C4C3C2C1);
    addr_q.delete();
    wwrap = 1'b1;
    wptr = 13'd2;
    drain(27, 1'b0, 80);
    chk("t3_reads", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("t3_addr0", addr_q[0], 127);
      chk("t3_addr1", addr_q[1], 0);
      chk("t3_addr2", addr_q[2], 1);
    end
    chk("t3_rwrap", rwrap, 1);
    chk("t3_rptr", rptr, 2);

    // 4: backpressure 1,0,0,1
    push_sample(2, 72'hD9D8D7D6D5D4D3D2D1);
    push_sample(3, 72'hE9E8E7E6E5E4E3E2E1);
    push_sample(4, 72'hF9F8F7F6F5F4F3F2F1);
    wptr = 13'd5;
    drain(27, 1'b1, 200);
    chk("t4_rptr", rptr, 5);
    chk("t4_left", exp_q.size(), 0);

    // 5: flush mid-sample with two more queued
    push_sample(5, 72'h1A1B1C1D1E1F2A2B2C);
    push_sample(6, 72'h3A3B3C3D3E3F4A4B4C);
    push_sample(7, 72'h5A5B5C5D5E5F6A6B6C);
    wptr = 13'd8;
    drain(4, 1'b0, 40);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_rptr", rptr, 8);
    chk("t5_rwrap", rwrap, 1);
    exp_q.delete();
    out_ready = 1'b1;
    seen_v = 1'b0; seen_r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen_v |= out_valid;
      seen_r |= ravail;
      tick();
    end
    chk("t5_quiet_valid", seen_v, 0);
    chk("t5_quiet_ravail", seen_r, 0);
    push_sample(8, 72'h7172737475767778AB);
    wptr = 13'd9;
    drain(9, 1'b0, 30);
    chk("t5_rptr_after", rptr, 9);

    // 6: reset mid-sample with a read in flight
    push_sample(9, 72'h818283848586878889);
    push_sample(10, 72'h919293949596979899);
    wptr = 13'd11;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (ravail && out_valid) found = 1'b1;
      else tick();
    end
    chk("t6_inflight", found, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_ravail", ravail, 0);
    chk("t6_raddr", raddr, 0);
    chk("t6_rptr", rptr, 0);
    chk("t6_rwrap", rwrap, 0);
    wptr = '0;
    wwrap = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    seen_v = 1'b0; seen_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_v |= out_valid;
      seen_r |= ravail;
    end
    chk("t6_quiet_valid", seen_v, 0);
    chk("t6_quiet_ravail", seen_r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
